top_level: RTL and testbench

- Self-contained message-encryption engine for Program 1.
- Holds a 256x8 data memory, instance `DM` with array `Core[0:255]`, preloaded by the bench.
- When started, reads parameters from memory and pads the message with ASCII spaces to 64 bytes.
- XORs each padded byte with a 7-bit LFSR stream, prepends an even-parity bit as bit 7, writes the 64 results to `Core[64..127]`, then raises `ack`.

---
 rtl/top_level_pkg.sv | 47 ++++
 rtl/dat_mem.sv | 34 +++
 rtl/top_level.sv | 155 +++++++++++++++
 tb/tb_top_level.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// ---------------------------------------------------------------------------
// top_level_pkg
// Shared constants for the message-encryption engine: FSM state encoding,
// memory map addresses, the LFSR tap table, and small helper functions
// (tap lookup and even parity).
// ---------------------------------------------------------------------------
package top_level_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LD_PRE  = 3'd1;
  localparam state_t ST_LD_PTN  = 3'd2;
  localparam state_t ST_LD_SEED = 3'd3;
  localparam state_t ST_ENC     = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] PTN_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam logic [7:0] MSG_MAX   = 8'd49;
  localparam logic [7:0] OUT_LAST  = 8'd63;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] PT_MAX    = 8'd8;

  localparam logic [6:0] TAP_TABLE [0:8] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Pattern numbers beyond the table fall back to the first entry.
  function automatic logic [6:0] tap_lookup(input logic [7:0] pt_no);
    logic [6:0] taps;
    if (pt_no <= PT_MAX) begin
      taps = TAP_TABLE[pt_no[3:0]];
    end else begin
      taps = TAP_TABLE[0];
    end
    return taps;
  endfunction

  // Bit that makes the total count of ones in {p, t} even.
  function automatic logic even_parity(input logic [6:0] t);
    return ^t;
  endfunction

endpackage

// File: rtl/dat_mem.sv
// ---------------------------------------------------------------------------
// dat_mem
// 256x8 data memory with combinational read and a single synchronous write
// port. Contents have no reset so externally preloaded data survives.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
// ---------------------------------------------------------------------------
module dat_mem (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] Core [0:255];

  // Asynchronous read path.
  assign rdata_o = Core[raddr_i];

  // Synchronous single-port write; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      Core[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level
// Message-encryption engine. After req falls it loads pre_length, pattern
// number and LFSR seed from memory, then produces 64 bytes: each padded
// message byte (ASCII space padding) XORed with a 7-bit LFSR stream, with an
// even-parity bit prepended as bit 7, written to Core[64..127]. ack is held
// high on completion until req returns high.
// Build option: define TAPS_RAW_EN to use Core[62][6:0] directly as the tap
// mask instead of the pattern-number table.
// Ports:
//   clk  - system clock, rising edge
//   init - asynchronous active-low reset
//   req  - start request (run launches when low in idle)
//   ack  - run complete flag
// ---------------------------------------------------------------------------
module top_level (
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  import top_level_pkg::*;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [7:0] pre_q, pre_d;
  logic [6:0] taps_q, taps_d;
  logic       ack_q, ack_d;

  logic [7:0] raddr_s;
  logic [7:0] rdata_s;
  logic       we_s;
  logic [7:0] waddr_s;
  logic [7:0] wdata_s;
  logic [7:0] src_s;
  logic       use_pad_s;
  logic [6:0] pad_s;
  logic [6:0] t_s;
  logic [6:0] lfsr_next_s;

  dat_mem DM (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Encryption datapath: 8-bit wrapping source index, padding select, XOR, parity.
  always_comb begin
    src_s       = i_q - pre_q;
    use_pad_s   = (i_q < pre_q) || (src_s >= MSG_MAX);
    pad_s       = use_pad_s ? SPACE[6:0] : rdata_s[6:0];
    t_s         = pad_s ^ lfsr_q;
    wdata_s     = {even_parity(t_s), t_s};
    waddr_s     = OUT_BASE + i_q;
    lfsr_next_s = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
  end

  // FSM next-state, memory read address and parameter latching.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    lfsr_d  = lfsr_q;
    pre_d   = pre_q;
    taps_d  = taps_q;
    ack_d   = ack_q;
    raddr_s = src_s;
    we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (!req) begin
          state_d = ST_LD_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LD_PRE: begin
        raddr_s = PRE_ADDR;
        pre_d   = rdata_s;
        i_d     = 8'd0;
        state_d = ST_LD_PTN;
      end
      ST_LD_PTN: begin
        raddr_s = PTN_ADDR;
`ifdef TAPS_RAW_EN
        taps_d  = rdata_s[6:0];
`else
        taps_d  = tap_lookup(rdata_s);
`endif
        state_d = ST_LD_SEED;
      end
      ST_LD_SEED: begin
        raddr_s = SEED_ADDR;
        // An all-zero seed would lock the LFSR, so it is forced to 1.
        if (rdata_s[6:0] == 7'h00) begin
          lfsr_d = 7'h01;
        end else begin
          lfsr_d = rdata_s[6:0];
        end
        state_d = ST_ENC;
      end
      ST_ENC: begin
        we_s   = 1'b1;
        lfsr_d = lfsr_next_s;
        i_d    = i_q + 8'd1;
        if (i_q == OUT_LAST) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_ENC;
        end
      end
      ST_DONE: begin
        if (req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q <= ST_IDLE;
      i_q     <= 8'd0;
      lfsr_q  <= 7'h00;
      pre_q   <= 8'd0;
      taps_q  <= 7'h00;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      lfsr_q  <= lfsr_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      ack_q   <= ack_d;
    end
  end

  assign ack = ack_q;

endmodule

// File: tb/tb_top_level.sv
// ---------------------------------------------------------------------------
// tb_top_level
// Randomized and directed stimulus for the encryption engine, checked against
// a behavioural model of the output bytes and the ack timing.
// ---------------------------------------------------------------------------
module tb_top_level;

  logic clk;
  logic init;
  logic req;
  logic ack;

  int n_vec;
  int n_mis;

  logic [7:0] msg_img  [49];
  logic [7:0] exp_out  [64];
  logic [7:0] base_out [64];
  logic [6:0] tap_tbl  [9];

  top_level dut (
    .clk  (clk),
    .init (init),
    .req  (req),
    .ack  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Preload the memory image and remember the message for the model.
  task automatic load(input string m, input logic [7:0] pre, input logic [7:0] pt, input logic [7:0] sd);
    for (int k = 0; k < 49; k++) begin
      msg_img[k] = (k < m.len()) ? m[k] : 8'h20;
      dut.DM.Core[k] = msg_img[k];
    end
    for (int k = 49; k < 61; k++) dut.DM.Core[k] = 8'h77;
    dut.DM.Core[61] = pre;
    dut.DM.Core[62] = pt;
    dut.DM.Core[63] = sd;
    for (int k = 64; k < 128; k++) dut.DM.Core[k] = 8'hAA;
    dut.DM.Core[128] = 8'h5A;
    dut.DM.Core[255] = 8'hC3;
  endtask

  // Reference: message placed after pre_length spaces, truncated to 64 bytes.
  task automatic model(input logic [7:0] pre, input logic [7:0] pt, input logic [7:0] sd);
    logic [6:0] lf;
    logic [6:0] tp;
    logic [7:0] pad;
    logic [6:0] t;
    int src;
`ifdef TAPS_RAW_EN
    tp = pt[6:0];
`else
    tp = (int'(pt) <= 8) ? tap_tbl[int'(pt)] : tap_tbl[0];
`endif
    lf = (sd[6:0] == 7'h00) ? 7'h01 : sd[6:0];
    for (int i = 0; i < 64; i++) begin
      src = i - int'(pre);
      if (i < int'(pre) || src >= 49) pad = 8'h20;
      else pad = msg_img[src];
      t = pad[6:0] ^ lf;
      exp_out[i] = {^t, t};
      lf = {lf[5:0], ^(lf & tp)};
    end
  endtask

  // Launch a run and check ack every cycle until it is released again.
  task automatic run_engine(input string tag);
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      @(posedge clk);
      #1 check($sformatf("%s ack cyc%0d", tag, k), {31'd0, ack}, (k == 68) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check($sformatf("%s ack hold%0d", tag, k), {31'd0, ack}, 32'd1);
    end
    req = 1'b1;
    @(posedge clk);
    #1 check($sformatf("%s ack release", tag), {31'd0, ack}, 32'd0);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s out[%0d]", tag, i), {24'd0, dut.DM.Core[64 + i]}, {24'd0, exp_out[i]});
    end
    check($sformatf("%s pre kept", tag), {24'd0, dut.DM.Core[48]}, {24'd0, msg_img[48]});
    check($sformatf("%s gap kept", tag), {24'd0, dut.DM.Core[55]}, 32'h77);
    check($sformatf("%s hi128 kept", tag), {24'd0, dut.DM.Core[128]}, 32'h5A);
    check($sformatf("%s hi255 kept", tag), {24'd0, dut.DM.Core[255]}, 32'hC3);
  endtask

  initial begin
    string watson;
    string fox;
    logic [7:0] lit [7];
    logic [7:0] pre, pt, sd;
    n_vec = 0;
    n_mis = 0;
    tap_tbl = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    lit = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
    watson = "Mr. Watson, come here. I want to see you.";
    fox = "The quick brown fox jumps over the lazy dog 12345";

    init = 1'b0;
    req  = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset ack", {31'd0, ack}, 32'd0);
    init = 1'b1;
    @(posedge clk);
    #1 check("idle ack", {31'd0, ack}, 32'd0);

    // Directed case with hand-computed leading bytes.
    load("A", 8'd10, 8'd0, 8'h01);
    model(8'd10, 8'd0, 8'h01);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("model lit[%0d]", i), {24'd0, exp_out[i]}, {24'd0, lit[i]});
      base_out[i] = exp_out[i];
    end
    for (int i = 7; i < 64; i++) base_out[i] = exp_out[i];
    run_engine("basic");
    check_out("basic");
    for (int i = 0; i < 7; i++)
      check($sformatf("basic lit[%0d]", i), {24'd0, dut.DM.Core[64 + i]}, {24'd0, lit[i]});

    // Zero seed behaves like seed 1.
    load("A", 8'd10, 8'd0, 8'h00);
    model(8'd10, 8'd0, 8'h00);
    run_engine("seed0");
    for (int i = 0; i < 64; i++)
      check($sformatf("seed0 vs base[%0d]", i), {24'd0, dut.DM.Core[64 + i]}, {24'd0, base_out[i]});

    // Core[62] = 0x60: out-of-table in default build, raw mask 0x60 otherwise.
    load("A", 8'd10, 8'h60, 8'h01);
    model(8'd10, 8'h60, 8'h01);
    run_engine("pt60");
    for (int i = 0; i < 64; i++)
      check($sformatf("pt60 vs base[%0d]", i), {24'd0, dut.DM.Core[64 + i]}, {24'd0, base_out[i]});

    // pt_no 12.
    load("A", 8'd10, 8'd12, 8'h01);
    model(8'd10, 8'd12, 8'h01);
    run_engine("pt12");
    check_out("pt12");
`ifndef TAPS_RAW_EN
    for (int i = 0; i < 64; i++)
      check($sformatf("pt12 vs base[%0d]", i), {24'd0, dut.DM.Core[64 + i]}, {24'd0, base_out[i]});
`endif

    // Randomized Watson runs.
    for (int r = 0; r < 6; r++) begin
      pre = 8'($urandom_range(10, 15));
      pt  = 8'($urandom_range(0, 8));
      sd  = 8'($urandom_range(1, 127));
      load(watson, pre, pt, sd);
      model(pre, pt, sd);
      run_engine($sformatf("watson%0d", r));
      check_out($sformatf("watson%0d", r));
    end

    // 49-character message, pre_length 15.
    load(fox, 8'd15, 8'd3, 8'h2B);
    model(8'd15, 8'd3, 8'h2B);
    run_engine("fox");
    check_out("fox");

    // Fully random parameters, including long pre_length and wild pt_no.
    for (int r = 0; r < 4; r++) begin
      string rnd;
      rnd = "";
      for (int k = 0; k < 49; k++) rnd = {rnd, string'(8'($urandom_range(32, 126)))};
      pre = 8'($urandom_range(0, 90));
      pt  = 8'($urandom_range(0, 255));
      sd  = 8'($urandom_range(0, 255));
      load(rnd, pre, pt, sd);
      model(pre, pt, sd);
      run_engine($sformatf("rand%0d", r));
      check_out($sformatf("rand%0d", r));
    end

    // Reset during encryption, then a clean re-run.
    load("A", 8'd10, 8'd0, 8'h01);
    model(8'd10, 8'd0, 8'h01);
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    repeat (24) @(posedge clk);
    #1 init = 1'b0;
    #1 check("midrst ack", {31'd0, ack}, 32'd0);
    check("midrst last written", {24'd0, dut.DM.Core[64 + 19]}, {24'd0, exp_out[19]});
    if (exp_out[20] != 8'hAA)
      check("midrst not written", {24'd0, dut.DM.Core[64 + 20]}, 32'hAA);
    req = 1'b1;
    @(posedge clk);
    #1 init = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("midrst idle ack", {31'd0, ack}, 32'd0);
    check("midrst idle no write", {24'd0, dut.DM.Core[64 + 25]}, 32'hAA);
    run_engine("rerun");
    check_out("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
